// File: rtl/symbols_pkg.sv
// Shared 8b/10b symbol constants and scrambler parameters for the TX
// scrambler and the RX descrambler, plus the per-symbol rule decode.
package symbols_pkg;

  localparam logic [7:0]  K_COM          = 8'hBC;
  localparam logic [7:0]  K_SKP          = 8'h1C;
  localparam logic [15:0] SCRAMBLER_SEED = 16'hFFFF;
  // Galois taps for X^16 + X^5 + X^4 + X^3 + 1 (bits 5, 4, 3, 0).
  localparam logic [15:0] SCRAMBLER_POLY = 16'h0039;

  typedef enum logic [2:0] {
    SYM_COM,    // reseed, pass through
    SYM_SKP,    // freeze, pass through
    SYM_K,      // other K-code: pass through, advance
    SYM_D_RAW,  // ordered-set / bypassed data: pass through, advance
    SYM_D_SCR   // scrambled data: xor key, advance
  } sym_kind_e;

  function automatic sym_kind_e classify_symbol(input logic       is_k,
                                                input logic [7:0] data,
                                                input logic       is_os,
                                                input logic       bypass);
    sym_kind_e kind;
    if (is_k && data == K_COM)      kind = SYM_COM;
    else if (is_k && data == K_SKP) kind = SYM_SKP;
    else if (is_k)                  kind = SYM_K;
    else if (is_os || bypass)       kind = SYM_D_RAW;
    else                            kind = SYM_D_SCR;
    return kind;
  endfunction

endpackage

// File: rtl/scrambler_lfsr_byte.sv
// Combinational 8-step advance of the 16-bit PCIe scrambler LFSR.
// Ports:
//   state_i  current LFSR state
//   state_o  state after 8 single-bit shifts
//   key_o    scrambling key; bit 0 is the LFSR output of the first shift
module scrambler_lfsr_byte
  import symbols_pkg::*;
(
  input  logic [15:0] state_i,
  output logic [15:0] state_o,
  output logic [7:0]  key_o
);

  logic [15:0] s;

  always_comb begin
    s     = state_i;
    key_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      key_o[i] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? SCRAMBLER_POLY : '0);
    end
    state_o = s;
  end

endmodule

// File: rtl/tx_scrambler_gen12.sv
// Per-lane TX scrambler for 2.5/5.0 GT/s. Scrambles D-symbols with the
// PCIe LFSR, passes K-symbols through, reseeds on COM, freezes on SKP.
// One-entry valid/ready output register, 1-cycle latency.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   valid_i/ready_o              input handshake
//   data_i, is_k_i               input symbol
//   is_ordered_set_i             symbol is TS1/TS2 body (not scrambled)
//   bypass_scrambler_i           scrambling disabled for this symbol
//   valid_o/ready_i              output handshake
//   data_o, is_k_o               output symbol
module tx_scrambler_gen12
  import symbols_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = SCRAMBLER_SEED
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  input  logic       is_k_i,
  input  logic       is_ordered_set_i,
  input  logic       bypass_scrambler_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       is_k_o
);

  logic [15:0] lfsr_q, lfsr_d, lfsr_next;
  logic [7:0]  key;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        is_k_q, is_k_d;
  logic        acc;
  sym_kind_e   kind;

  scrambler_lfsr_byte u_lfsr (
    .state_i (lfsr_q),
    .state_o (lfsr_next),
    .key_o   (key)
  );

  assign ready_o = ready_i || !valid_q;
  assign acc     = valid_i && ready_o;
  assign kind    = classify_symbol(is_k_i, data_i, is_ordered_set_i, bypass_scrambler_i);

  always_comb begin
    lfsr_d  = lfsr_q;
    valid_d = valid_q;
    data_d  = data_q;
    is_k_d  = is_k_q;
    if (acc) begin
      valid_d = 1'b1;
      data_d  = data_i;
      is_k_d  = is_k_i;
      unique case (kind)
        SYM_COM:   lfsr_d = LFSR_SEED;
        SYM_SKP:   lfsr_d = lfsr_q;
        SYM_K,
        SYM_D_RAW: lfsr_d = lfsr_next;
        SYM_D_SCR: begin
          data_d = data_i ^ key;
          lfsr_d = lfsr_next;
        end
        default:   lfsr_d = lfsr_q;
      endcase
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q  <= LFSR_SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
      is_k_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      is_k_q  <= is_k_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign is_k_o  = is_k_q;

endmodule

// File: tb/tb_tx_scrambler_gen12.sv
module tb_tx_scrambler_gen12;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       valid_i, ready_o;
  logic [7:0] data_i;
  logic       is_k_i, is_ordered_set_i, bypass_scrambler_i;
  logic       valid_o, ready_i;
  logic [7:0] data_o;
  logic       is_k_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tx_scrambler_gen12 #(.LFSR_SEED(16'hFFFF)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .data_i             (data_i),
    .is_k_i             (is_k_i),
    .is_ordered_set_i   (is_ordered_set_i),
    .bypass_scrambler_i (bypass_scrambler_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .data_o             (data_o),
    .is_k_o             (is_k_o)
  );

  typedef struct {
    logic       k;
    logic [7:0] d;
    logic       os;
    logic       byp;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic k, input logic [7:0] d, input logic os,
                     input logic byp, input logic [7:0] exp);
    vec_t v;
    v.k = k; v.d = d; v.os = os; v.byp = byp; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic v, input logic k, input logic [7:0] d,
                       input logic os, input logic byp);
    valid_i = v; is_k_i = k; data_i = d; is_ordered_set_i = os; bypass_scrambler_i = byp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent bit-serial reference written from the tap equations.
  task automatic ref_byte(input logic [15:0] st, output logic [7:0] key,
                          output logic [15:0] nxt);
    logic [15:0] b, nb;
    b = st;
    for (int j = 0; j < 8; j++) begin
      key[j] = b[15];
      nb[0] = b[15];
      nb[1] = b[0];
      nb[2] = b[1];
      nb[3] = b[2] ^ b[15];
      nb[4] = b[3] ^ b[15];
      nb[5] = b[4] ^ b[15];
      for (int m = 6; m < 16; m++) nb[m] = b[m-1];
      b = nb;
    end
    nxt = b;
  endtask

  logic [15:0] m_lfsr;
  logic        m_v, m_k;
  logic [7:0]  m_d;

  initial begin
    logic [7:0]  exp_seq [8];
    logic [7:0]  key;
    logic [15:0] nxt;
    logic        acc, exp_rdy;
    int          sel;

    exp_seq = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
    rst_i = 1'b1; ready_i = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("reset_valid_o", {15'd0, valid_o}, 16'd0);
    chk("reset_data_o",  {8'd0, data_o},   16'd0);
    chk("reset_is_k_o",  {15'd0, is_k_o},  16'd0);
    chk("reset_ready_o", {15'd0, ready_o}, 16'd1);
    #22 rst_i = 1'b0;
    tick();

    // Directed table, ready_i held high (full throughput).
    add(1, 8'hBC, 0, 0, 8'hBC);
    for (int i = 0; i < 8; i++) add(0, 8'h00, 0, 0, exp_seq[i]);
    add(1, 8'hBC, 0, 0, 8'hBC); add(0, 8'h00, 0, 0, 8'hFF);
    add(1, 8'h1C, 0, 0, 8'h1C); add(1, 8'h1C, 0, 0, 8'h1C);
    add(0, 8'h00, 0, 0, 8'h17);
    add(1, 8'hBC, 0, 0, 8'hBC); add(0, 8'h00, 1, 0, 8'h00); add(0, 8'h00, 0, 0, 8'h17);
    add(1, 8'hBC, 0, 0, 8'hBC); add(0, 8'h00, 0, 1, 8'h00); add(0, 8'h00, 0, 0, 8'h17);
    add(1, 8'hBC, 0, 0, 8'hBC); add(1, 8'hBC, 0, 0, 8'hBC); add(0, 8'h00, 0, 0, 8'hFF);
    add(1, 8'hBC, 0, 0, 8'hBC); add(1, 8'hFC, 0, 0, 8'hFC); add(0, 8'h00, 0, 0, 8'h17);
    add(1, 8'hBC, 0, 0, 8'hBC); add(0, 8'hA5, 0, 0, 8'h5A);
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].k, tbl[i].d, tbl[i].os, tbl[i].byp);
      tick();
      chk($sformatf("tbl%0d_data", i),  {8'd0, data_o},  {8'd0, tbl[i].exp});
      chk($sformatf("tbl%0d_valid", i), {15'd0, valid_o}, 16'd1);
      chk($sformatf("tbl%0d_is_k", i),  {15'd0, is_k_o},  {15'd0, tbl[i].k});
    end

    // Backpressure: COM sits in the output register while ready_i is low.
    drive(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0);
    tick();
    ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready_o", {15'd0, ready_o}, 16'd0);
      tick();
      chk("bp_data_hold",  {8'd0, data_o},   16'h00BC);
      chk("bp_valid_hold", {15'd0, valid_o}, 16'd1);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_resume%0d", i), {8'd0, data_o}, {8'd0, exp_seq[i]});
    end

    // Reset mid-stream with a pending output.
    drive(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    end
    chk("pre_rst_data", {8'd0, data_o}, 16'h00C0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 rst_i = 1'b1;
    #1 chk("rst_async_valid", {15'd0, valid_o}, 16'd0);
    chk("rst_async_data", {8'd0, data_o}, 16'd0);
    #2 rst_i = 1'b0;
    tick();
    drive(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0); tick();
    chk("post_rst_com", {8'd0, data_o}, 16'h00BC);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); tick();
    chk("post_rst_key", {8'd0, data_o}, 16'h00FF);

    // Random run against the reference model; starts from a fresh reset.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    m_lfsr = 16'hFFFF; m_v = 1'b0; m_d = 8'h00; m_k = 1'b0;
    tick();
    for (int n = 0; n < 3000; n++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      is_k_i  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      data_i = (is_k_i && sel == 0) ? 8'hBC : (is_k_i && sel == 1) ? 8'h1C : 8'($urandom);
      is_ordered_set_i   = ($urandom_range(0, 7) == 0);
      bypass_scrambler_i = ($urandom_range(0, 7) == 0);
      exp_rdy = ready_i || !m_v;
      #1 chk("rnd_ready_o", {15'd0, ready_o}, {15'd0, exp_rdy});
      acc = valid_i && exp_rdy;
      ref_byte(m_lfsr, key, nxt);
      if (acc) begin
        m_v = 1'b1; m_k = is_k_i; m_d = data_i;
        if (is_k_i && data_i == 8'hBC)      m_lfsr = 16'hFFFF;
        else if (is_k_i && data_i == 8'h1C) m_lfsr = m_lfsr;
        else begin
          if (!is_k_i && !is_ordered_set_i && !bypass_scrambler_i) m_d = data_i ^ key;
          m_lfsr = nxt;
        end
      end else if (ready_i) begin
        m_v = 1'b0;
      end
      tick();
      chk("rnd_valid_o", {15'd0, valid_o}, {15'd0, m_v});
      chk("rnd_data_o",  {8'd0, data_o},   {8'd0, m_d});
      chk("rnd_is_k_o",  {15'd0, is_k_o},  {15'd0, m_k});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
